// File: rtl/snd_pkg.sv
// rtl/snd_pkg.sv - shared constants, defaults and FSM states for the sound volume path
// Gain ramping in snd_vol_ramp is built only when SND_VOL_RAMP_EN is defined.
package snd_pkg;

  localparam int SND_SAMPLE_W = 16;
  localparam int SND_CH       = 2;
  localparam int SND_VOL_W    = 8;

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } vol_state_e;

  // Full-scale gain value: passthrough in the gain law.
  function automatic int vol_max(input int vol_w);
    return (1 << vol_w) - 1;
  endfunction

endpackage

// File: rtl/snd_vol_mul.sv
// rtl/snd_vol_mul.sv - one channel's gain law: y = (x * (g+1)) >>> VOL_W, with exact 0 and full-scale ends
// Purely combinational; sits between the two pipeline stages of snd_vol_ramp.
module snd_vol_mul
  import snd_pkg::*;
#(
  parameter int SAMPLE_W = SND_SAMPLE_W,
  parameter int VOL_W    = SND_VOL_W
) (
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic        [VOL_W-1:0]    i_gain,
  input  logic                       i_used,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  localparam int P_W = SAMPLE_W + VOL_W + 1;
  localparam logic [VOL_W-1:0] VMAX = VOL_W'(vol_max(VOL_W));

  logic signed [P_W-1:0] w_x;
  logic signed [P_W-1:0] w_k;

  assign w_x = P_W'(i_sample);
  assign w_k = P_W'({1'b0, i_gain}) + P_W'(1);

  always_comb begin
    o_sample = SAMPLE_W'((w_x * w_k) >>> VOL_W);
    if (!i_used || (i_gain == '0)) begin
      o_sample = '0;
    end else if (i_gain == VMAX) begin
      o_sample = i_sample;
    end
  end

endmodule

// File: rtl/snd_vol_ramp.sv
// rtl/snd_vol_ramp.sv - pipelined CH-channel volume stage whose gain steps toward the target per frame
// SND_VOL_RAMP_EN builds the ramp FSM; without it the gain loads the target on every accepted frame.
module snd_vol_ramp
  import snd_pkg::*;
#(
  parameter int SAMPLE_W  = SND_SAMPLE_W,
  parameter int CH        = SND_CH,
  parameter int VOL_W     = SND_VOL_W,
  parameter int RAMP_STEP = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   USED,
  input  logic                   MUTE,
  input  logic [VOL_W-1:0]       VOLUME,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic [CH*SAMPLE_W-1:0] S_DATA,
  output logic                   M_VALID,
  input  logic                   M_READY,
  output logic [CH*SAMPLE_W-1:0] M_DATA,
  output logic [VOL_W-1:0]       GAIN,
  output logic                   RAMPING
);

  localparam int DATA_W = CH * SAMPLE_W;
`ifdef SND_VOL_RAMP_EN
  localparam int STEP = RAMP_STEP;
`else
  // A step of at least full scale always lands on the target in one frame.
  localparam int STEP = RAMP_STEP | vol_max(VOL_W);
`endif
  localparam logic [VOL_W-1:0] STEP_V = VOL_W'(STEP);

  logic [VOL_W-1:0]  w_target, w_up, w_dn, w_gain_next, r_gain;
  logic              w_stall, w_accept;
  logic              r_s1_valid, r_s1_used, r_s2_valid;
  logic [VOL_W-1:0]  r_s1_gain;
  logic [DATA_W-1:0] r_s1_data, r_s2_data, w_scaled;

  assign w_target = MUTE ? '0 : VOLUME;
  assign w_stall  = r_s2_valid && !M_READY;
  assign w_accept = S_VALID && !w_stall;
  assign w_up     = w_target - r_gain;
  assign w_dn     = r_gain - w_target;

  always_comb begin
    w_gain_next = r_gain;
    if (w_accept) begin
      if (w_target > r_gain) begin
        w_gain_next = r_gain + ((w_up > STEP_V) ? STEP_V : w_up);
      end else if (w_target < r_gain) begin
        w_gain_next = r_gain - ((w_dn > STEP_V) ? STEP_V : w_dn);
      end
    end
  end

  // Both stages advance together, so a stall never creates or drops a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gain     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_used  <= 1'b0;
      r_s1_gain  <= '0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_gain <= w_gain_next;
      if (!w_stall) begin
        r_s1_valid <= S_VALID;
        r_s2_valid <= r_s1_valid;
        if (S_VALID) begin
          r_s1_data <= S_DATA;
          r_s1_gain <= r_gain;
          r_s1_used <= USED;
        end
        if (r_s1_valid) begin
          r_s2_data <= w_scaled;
        end
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    snd_vol_mul #(
      .SAMPLE_W(SAMPLE_W),
      .VOL_W   (VOL_W)
    ) u_mul (
      .i_sample(r_s1_data[k*SAMPLE_W +: SAMPLE_W]),
      .i_gain  (r_s1_gain),
      .i_used  (r_s1_used),
      .o_sample(w_scaled[k*SAMPLE_W +: SAMPLE_W])
    );
  end

`ifdef SND_VOL_RAMP_EN
  vol_state_e r_state, w_state_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HOLD:    if (w_gain_next != w_target) w_state_next = RAMP;
      RAMP:    if (w_gain_next == w_target) w_state_next = HOLD;
      default: w_state_next = HOLD;
    endcase
  end

  assign RAMPING = (r_state == RAMP);
`else
  assign RAMPING = 1'b0;
`endif

  assign S_READY = !w_stall;
  assign M_VALID = r_s2_valid;
  assign M_DATA  = r_s2_data;
  assign GAIN    = r_gain;

endmodule

// File: tb/tb_snd_vol_ramp.sv
// tb/tb_snd_vol_ramp.sv - table-driven and randomized bench for snd_vol_ramp with a frame-level model
// Expectations follow SND_VOL_RAMP_EN the same way the design does.
module tb_snd_vol_ramp;

  localparam int SW = 16;
  localparam int CH = 2;
  localparam int VW = 8;
  localparam int STEP = 16;
  localparam int GMAX = (1 << VW) - 1;
`ifdef SND_VOL_RAMP_EN
  localparam int  MODEL_STEP = STEP;
  localparam bit  RAMP_ON    = 1'b1;
  localparam logic [VW-1:0] FIRST_UP   = 8'h10;
  localparam logic [VW-1:0] FIRST_DOWN = 8'hEF;
  localparam logic [31:0]   START_Y1   = 32'h0440_0440;
`else
  localparam int  MODEL_STEP = 256;
  localparam bit  RAMP_ON    = 1'b0;
  localparam logic [VW-1:0] FIRST_UP   = 8'hFF;
  localparam logic [VW-1:0] FIRST_DOWN = 8'h00;
  localparam logic [31:0]   START_Y1   = 32'h2040_2040;
`endif

  logic clk = 1'b0, rst = 1'b0, used = 1'b1, mute = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [VW-1:0] volume = '0;
  logic [CH*SW-1:0] s_data = '0;
  logic s_ready, m_valid, ramping;
  logic [CH*SW-1:0] m_data;
  logic [VW-1:0] gain;

  snd_vol_ramp #(.SAMPLE_W(SW), .CH(CH), .VOL_W(VW), .RAMP_STEP(STEP)) dut (
    .CLK(clk), .RST(rst), .USED(used), .MUTE(mute), .VOLUME(volume),
    .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
    .GAIN(gain), .RAMPING(ramping)
  );

  always #5 clk = ~clk;

  typedef struct { logic [CH*SW-1:0] y; int age; } fr_t;
  typedef struct { logic [7:0] g; bit u; logic [15:0] x0, x1, y0, y1; } vec_t;

  fr_t q[$];
  logic [CH*SW-1:0] dut_out[$];
  int g_m = 0;
  bit ramp_m = 1'b0;
  int n_vec = 0, n_err = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*SW-1:0] law(input logic [CH*SW-1:0] x, input int g, input bit u);
    logic [CH*SW-1:0] r;
    logic signed [SW-1:0] xs;
    longint p;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      xs = x[k*SW +: SW];
      if (!u || g == 0) r[k*SW +: SW] = '0;
      else if (g == GMAX) r[k*SW +: SW] = xs;
      else begin
        p = longint'(xs) * longint'(g + 1);
        r[k*SW +: SW] = SW'(p >>> VW);
      end
    end
    return r;
  endfunction

  function automatic int move(input int g, input int t);
    if (t > g) return g + (((t - g) < MODEL_STEP) ? (t - g) : MODEL_STEP);
    if (t < g) return g - (((g - t) < MODEL_STEP) ? (g - t) : MODEL_STEP);
    return g;
  endfunction

  // Called at a falling edge with inputs set: checks outputs, advances the model, runs one clock.
  task automatic tick();
    bit mv, stall;
    int t;
    fr_t f;
    #1;
    mv = (q.size() > 0) && (q[0].age >= 1);
    chk("m_valid", 64'(m_valid), 64'(mv));
    chk("s_ready", 64'(s_ready), 64'(!(mv && !m_ready)));
    chk("gain", 64'(gain), 64'(g_m));
    chk("ramping", 64'(ramping), 64'(ramp_m));
    if (mv) chk("m_data", 64'(m_data), 64'(q[0].y));
    stall = mv && !m_ready;
    t = mute ? 0 : int'(volume);
    if (!stall) begin
      if (mv) begin
        dut_out.push_back(m_data);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age = 1;
      if (s_valid) begin
        f.y = law(s_data, g_m, used);
        f.age = 0;
        q.push_back(f);
        g_m = move(g_m, t);
      end
    end
    ramp_m = RAMP_ON && (g_m != t);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_gain", 64'(gain), 64'd0);
    chk("rst_ramping", 64'(ramping), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    g_m = 0;
    ramp_m = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    #1;
    chk("drain_idle", 64'(m_valid), 64'd0);
  endtask

  task automatic set_gain(input logic [VW-1:0] v);
    volume = v;
    mute = 1'b0;
    used = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 40 && g_m != int'(v); i++) begin
      s_data = $urandom;
      tick();
    end
    drain();
  endtask

  initial begin
    tbl[0] = '{8'h7F, 1'b1, 16'h8000, 16'h7FFF, 16'hC000, 16'h3FFF};
    tbl[1] = '{8'h7F, 1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
    tbl[2] = '{8'hFF, 1'b1, 16'h1234, 16'h8000, 16'h1234, 16'h8000};
    tbl[3] = '{8'hFF, 1'b0, 16'h1234, 16'h1234, 16'h0000, 16'h0000};
    tbl[4] = '{8'h00, 1'b1, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
    tbl[5] = '{8'h80, 1'b1, 16'h4000, 16'hC000, 16'h2040, 16'hDFC0};
    tbl[6] = '{8'h01, 1'b1, 16'h7FFF, 16'h8000, 16'h00FF, 16'hFF00};
    tbl[7] = '{8'hFE, 1'b1, 16'h7FFF, 16'h8001, 16'h7F7F, 16'h8080};
    tbl[8] = '{8'h40, 1'b1, 16'h0100, 16'hFF00, 16'h0041, 16'hFFBF};
    tbl[9] = '{8'h10, 1'b1, 16'h0003, 16'hFFFD, 16'h0000, 16'hFFFF};

    volume = 8'hFF;
    do_reset();

    // Fade-in from reset.
    s_valid = 1'b1;
    s_data = 32'h4000_4000;
    tick();
    chk("fadein_first_gain", 64'(gain), 64'(FIRST_UP));
    for (int i = 1; i < 300; i++) tick();
    drain();
    chk("fadein_last_y", 64'(dut_out[$]), 64'h4000_4000);
    chk("fadein_gain", 64'(gain), 64'hFF);
    chk("fadein_ramping", 64'(ramping), 64'd0);

    // Mute fade-out.
    mute = 1'b1;
    s_valid = 1'b1;
    tick();
    chk("mute_first_gain", 64'(gain), 64'(FIRST_DOWN));
    for (int i = 1; i < 20; i++) tick();
    drain();
    chk("mute_last_y", 64'(dut_out[$]), 64'd0);
    chk("mute_gain", 64'(gain), 64'd0);
    chk("mute_ramping", 64'(ramping), 64'd0);

    // Gain-law table.
    foreach (tbl[i]) begin
      set_gain(tbl[i].g);
      dut_out.delete();
      used = tbl[i].u;
      s_data = {tbl[i].x1, tbl[i].x0};
      s_valid = 1'b1;
      tick();
      used = 1'b1;
      drain();
      chk("tbl_count", 64'(dut_out.size()), 64'd1);
      if (dut_out.size() > 0) chk("tbl_y", 64'(dut_out[$]), 64'({tbl[i].y1, tbl[i].y0}));
      chk("tbl_gain_kept", 64'(gain), 64'(tbl[i].g));
    end

    // Backpressure: pipeline fills, then everything drains in order.
    begin
      int nrdy;
      set_gain(8'h7F);
      dut_out.delete();
      m_ready = 1'b0;
      s_valid = 1'b1;
      nrdy = 0;
      for (int i = 0; i < 10; i++) begin
        s_data = $urandom;
        #1;
        if (s_ready) nrdy++;
        tick();
      end
      chk("stall_accepted", 64'(nrdy), 64'd2);
      drain();
      chk("stall_out_count", 64'(dut_out.size()), 64'd2);
    end

`ifdef SND_VOL_RAMP_EN
    // Direction reversal mid-ramp.
    set_gain(8'h00);
    volume = 8'hFF;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rev_up_gain", 64'(gain), 64'h40);
    volume = 8'h10;
    tick();
    chk("rev_down_gain", 64'(gain), 64'h30);
    tick();
    tick();
    chk("rev_final_gain", 64'(gain), 64'h10);
    chk("rev_ramping", 64'(ramping), 64'd0);
    drain();
`endif

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) volume = 8'($urandom);
      if ($urandom_range(0, 29) == 0) mute = ~mute;
      used = ($urandom_range(0, 9) != 0);
      s_valid = ($urandom_range(0, 9) < 7);
      m_ready = ($urandom_range(0, 9) < 7);
      s_data = $urandom;
      tick();
    end
    mute = 1'b0;
    used = 1'b1;
    drain();

    // Reset with frames in flight, then start-up with VOLUME=0x80.
    volume = 8'h80;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    dut_out.delete();
    s_data = 32'h4000_4000;
    s_valid = 1'b1;
    tick();
    tick();
    drain();
    chk("start_count", 64'(dut_out.size()), 64'd2);
    if (dut_out.size() == 2) begin
      chk("start_y0", 64'(dut_out[0]), 64'd0);
      chk("start_y1", 64'(dut_out[1]), 64'(START_Y1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
